pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
Central sequencer for the five-stage pipeline's register enables and bubble insertion.
- Merges stall and flush requests from four sources: load-use hazard detection, EX-stage branch resolution, ID-stage jumps, and the instruction/data memory handshakes.
- Also sequences a fixed-latency multi-cycle multiply/divide occupying EX.
- Drives per-stage write enables and flushes (bubble = NOP load), and keeps a saturating stall-cycle performance counter.

Parameters:
MULDIV_CYCLES, 32, total cycles a mul/div instruction occupies EX (legal range 2..63).
CNT_W, 6, width of the mul/div countdown counter.
PERF_W, 32, width of the stall-cycle counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
load_use_hazard  in  1  load-use hazard between ID/EX load and IF/ID instruction.
branch_taken  in  1  branch resolved taken in EX.
jump_id  in  1  unconditional jump decoded in ID.
imem_ready  in  1  instruction fetch complete this cycle.
dmem_req  in  1  MEM-stage instruction is a load/store.
dmem_ready  in  1  data memory access completes this cycle.
muldiv_start  in  1  EX holds a mul/div instruction.
perf_clr  in  1  synchronous clear of stall_cycles.
pc_write  out  1  PC register enable.
if_id_write  out  1  IF/ID enable.
id_ex_write  out  1  ID/EX enable.
ex_mem_write  out  1  EX/MEM enable.
if_id_flush  out  1  load NOP into IF/ID.
id_ex_flush  out  1  load NOP into ID/EX.
ex_mem_flush  out  1  load NOP into EX/MEM.
mem_wb_flush  out  1  load NOP into MEM/WB.
muldiv_done  out  1  mul/div result valid this cycle; EX/MEM captures it.
ctrl_state  out  2  current FSM state.
stall_cycles  out  PERF_W  count of cycles with pc_write=0.

Behaviour:
- States: RUN=0, MEM_WAIT=1, MULDIV=2. Reset state is RUN; cnt=0; stall_cycles=0.
- While rst_n=0: all *_write=0, all *_flush=1, muldiv_done=0.
- Outputs are combinational from state and inputs. Flush overrides write in the target register. A frozen register has write=0 and flush=0. mem_wb is written every cycle unless flushed.
- RUN priority, first match wins:
  1. Data-memory stall (dmem_req & !dmem_ready): pc/if_id/id_ex/ex_mem write=0; mem_wb_flush=1; next state MEM_WAIT.
  2. muldiv_start: pc/if_id/id_ex write=0; ex_mem_flush=1; cnt<=MULDIV_CYCLES-1; next state MULDIV.
  3. branch_taken: all writes=1; if_id_flush=1; id_ex_flush=1.
  4. load_use_hazard: pc/if_id write=0; id_ex_flush=1; id_ex/ex_mem write=1.
  5. jump_id: all writes=1; if_id_flush=1.
  6. !imem_ready: pc_write=0; if_id_flush=1; others write=1.
  7. Otherwise: all writes=1, no flush.
- MEM_WAIT:
  - While !dmem_ready: same outputs as RUN item 1.
  - Cycle dmem_ready=1: evaluate as RUN items 3-7; muldiv_start is ignored that cycle; next state RUN.
- MULDIV:
  - Every cycle: pc/if_id/id_ex write=0.
  - When cnt>1 and no data-memory stall: ex_mem_flush=1, cnt decrements.
  - When a data-memory stall is active: RUN item 1 outputs apply. cnt still decrements while >1, but holds at 1.
  - Release cycle (cnt==1 and no data-memory stall): muldiv_done=1, ex_mem_write=1, then next state RUN. pc/if_id/id_ex still frozen that cycle. Hazard inputs are ignored for the whole MULDIV state.
  - EX occupancy is exactly MULDIV_CYCLES cycles when no memory stall occurs.
- stall_cycles: increments on each cycle with pc_write=0 and rst_n=1; saturates at all-ones; perf_clr wins over increment.
- Asynchronous reset mid-MULDIV or mid-MEM_WAIT: immediate return to RUN, cnt=0, the in-flight operation is abandoned.

Decomposition:
- Package pipeline_ctrl_pkg: state encoding constants (RUN, MEM_WAIT, MULDIV) and the default MULDIV_CYCLES.
- One sub-module: stall_perf_counter, a saturating counter with clear and enable, PERF_W parameter.

Test Plan:
1. load_use_hazard=1 for one cycle in RUN -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle; stall_cycles 0->1.
2. branch_taken=1 and load_use_hazard=1 together -> if_id_flush=1, id_ex_flush=1, pc_write=1; no stall.
3. MULDIV_CYCLES=4, muldiv_start held high -> ctrl_state 0,2,2,2 then 0; muldiv_done=1 only on cycle 4; pc_write=0 for 4 cycles.
4. dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> mem_wb_flush=1 and ex_mem_write=0 for 3 cycles; state MEM_WAIT then RUN; stall_cycles=3.
5. Data-memory stall asserted during MULDIV at cnt=1 for 2 cycles -> muldiv_done held off; it asserts on the first cycle with dmem_ready=1.
6. rst_n driven low mid-MULDIV -> ctrl_state=0 immediately, all flushes=1; after release, RUN behaviour with stall_cycles=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall controller: FSM states, the
// bundled stage-control vector and the RUN-state hazard priority chain.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MULDIV   = 2'd2
    } ctrl_state_e;

    localparam int MULDIV_CYCLES_DEF = 32;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
        logic muldiv_done;
    } ctl_t;

    localparam ctl_t CTL_FLOW  = ctl_t'(9'b1111_0000_0);
    localparam ctl_t CTL_RESET = ctl_t'(9'b0000_1111_0);

    // Hazards that only redirect or bubble the front end; shared by RUN and
    // the MEM_WAIT release cycle.
    function automatic ctl_t hazard_ctl(input logic branch_taken,
                                        input logic load_use_hazard,
                                        input logic jump_id,
                                        input logic imem_ready);
        ctl_t c;
        c = CTL_FLOW;
        if (branch_taken) begin
            c.if_id_flush = 1'b1;
            c.id_ex_flush = 1'b1;
        end else if (load_use_hazard) begin
            c.pc_write    = 1'b0;
            c.if_id_write = 1'b0;
            c.id_ex_flush = 1'b1;
        end else if (jump_id) begin
            c.if_id_flush = 1'b1;
        end else if (!imem_ready) begin
            c.pc_write    = 1'b0;
            c.if_id_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/stall_perf_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module stall_perf_counter #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic [PERF_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && (count != '1))
            count <= count + PERF_W'(1);
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Five-stage pipeline sequencer: merges hazard and memory stalls, runs the
// fixed-latency mul/div occupancy of EX, and counts PC-stall cycles.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF,
    parameter int CNT_W         = 6,
    parameter int PERF_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_use_hazard,
    input  logic              branch_taken,
    input  logic              jump_id,
    input  logic              imem_ready,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    input  logic              muldiv_start,
    input  logic              perf_clr,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_write,
    output logic              ex_mem_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mem_wb_flush,
    output logic              muldiv_done,
    output logic [1:0]        ctrl_state,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ctrl_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    ctl_t             ctl;
    logic             dstall;

    assign dstall = dmem_req & ~dmem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (dstall) begin
                    state_nxt = MEM_WAIT;
                end else if (muldiv_start) begin
                    state_nxt = MULDIV;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready)
                    state_nxt = RUN;
            end
            MULDIV: begin
                // The countdown keeps running under a memory stall but parks at 1
                // so the result is only handed over once EX/MEM can accept it.
                if (cnt > CNT_ONE) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else if (!dstall) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        ctl = CTL_FLOW;
        if (!rst_n) begin
            ctl = CTL_RESET;
        end else begin
            case (state)
                RUN: begin
                    if (dstall) begin
                        ctl              = '0;
                        ctl.mem_wb_flush = 1'b1;
                    end else if (muldiv_start) begin
                        ctl.pc_write     = 1'b0;
                        ctl.if_id_write  = 1'b0;
                        ctl.id_ex_write  = 1'b0;
                        ctl.ex_mem_flush = 1'b1;
                    end else begin
                        ctl = hazard_ctl(branch_taken, load_use_hazard, jump_id, imem_ready);
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_ready) begin
                        ctl              = '0;
                        ctl.mem_wb_flush = 1'b1;
                    end else begin
                        ctl = hazard_ctl(branch_taken, load_use_hazard, jump_id, imem_ready);
                    end
                end
                MULDIV: begin
                    ctl.pc_write    = 1'b0;
                    ctl.if_id_write = 1'b0;
                    ctl.id_ex_write = 1'b0;
                    if (dstall) begin
                        ctl.ex_mem_write = 1'b0;
                        ctl.mem_wb_flush = 1'b1;
                    end else if (cnt > CNT_ONE) begin
                        ctl.ex_mem_flush = 1'b1;
                    end else begin
                        ctl.muldiv_done = 1'b1;
                    end
                end
                default: ctl = CTL_FLOW;
            endcase
        end
    end

    assign pc_write     = ctl.pc_write;
    assign if_id_write  = ctl.if_id_write;
    assign id_ex_write  = ctl.id_ex_write;
    assign ex_mem_write = ctl.ex_mem_write;
    assign if_id_flush  = ctl.if_id_flush;
    assign id_ex_flush  = ctl.id_ex_flush;
    assign ex_mem_flush = ctl.ex_mem_flush;
    assign mem_wb_flush = ctl.mem_wb_flush;
    assign muldiv_done  = ctl.muldiv_done;
    assign ctrl_state   = state;

    stall_perf_counter #(.PERF_W(PERF_W)) u_perf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (perf_clr),
        .en    (~pc_write),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with MULDIV_CYCLES=4, PERF_W=4.
module tb_pipeline_stall_controller;

    localparam int PW = 4;

    // {pc, if_id, id_ex, ex_mem write, if_id, id_ex, ex_mem, mem_wb flush, done}
    localparam logic [8:0] C_ALL  = 9'b1111_0000_0;
    localparam logic [8:0] C_LU   = 9'b0011_0100_0;
    localparam logic [8:0] C_BR   = 9'b1111_1100_0;
    localparam logic [8:0] C_JMP  = 9'b1111_1000_0;
    localparam logic [8:0] C_IMEM = 9'b0111_1000_0;
    localparam logic [8:0] C_DST  = 9'b0000_0001_0;
    localparam logic [8:0] C_MD   = 9'b0001_0010_0;
    localparam logic [8:0] C_DONE = 9'b0001_0000_1;
    localparam logic [8:0] C_RST  = 9'b0000_1111_0;

    logic clk = 1'b0;
    logic rst_n;
    logic load_use_hazard, branch_taken, jump_id, imem_ready;
    logic dmem_req, dmem_ready, muldiv_start, perf_clr;
    logic pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, muldiv_done;
    logic [1:0]    ctrl_state;
    logic [PW-1:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.MULDIV_CYCLES(4), .CNT_W(6), .PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
        .jump_id(jump_id), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .muldiv_start(muldiv_start), .perf_clr(perf_clr),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .muldiv_done(muldiv_done), .ctrl_state(ctrl_state),
        .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Checks at the falling edge of the current cycle, then advances to just after the next rising edge.
    task automatic cycle(input string tag, input logic [8:0] ctl, input logic [1:0] st, input int sc);
        @(negedge clk);
        chk({tag, ".ctl"}, 32'({pc_write, if_id_write, id_ex_write, ex_mem_write,
                                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                                muldiv_done}), 32'(ctl));
        chk({tag, ".state"}, 32'(ctrl_state), 32'(st));
        chk({tag, ".stall"}, 32'(stall_cycles), 32'(sc));
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        load_use_hazard = 0; branch_taken = 0; jump_id = 0; imem_ready = 1;
        dmem_req = 0; dmem_ready = 1; muldiv_start = 0; perf_clr = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #3;
        chk("reset.ctl", 32'({pc_write, if_id_write, id_ex_write, ex_mem_write,
                              if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                              muldiv_done}), 32'(C_RST));
        chk("reset.state", 32'(ctrl_state), 32'd0);
        chk("reset.stall", 32'(stall_cycles), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Front-end hazard priorities in RUN
        cycle("idle", C_ALL, 2'd0, 0);
        load_use_hazard = 1;                     cycle("lu", C_LU, 2'd0, 0);
        branch_taken = 1;                        cycle("br_lu", C_BR, 2'd0, 1);
        idle(); jump_id = 1;                     cycle("jmp", C_JMP, 2'd0, 1);
        idle(); imem_ready = 0;                  cycle("imem", C_IMEM, 2'd0, 1);
        idle(); jump_id = 1; load_use_hazard = 1; cycle("jmp_lu", C_LU, 2'd0, 2);
        idle(); branch_taken = 1; imem_ready = 0; cycle("br_imem", C_BR, 2'd0, 3);
        idle();                                  cycle("idle2", C_ALL, 2'd0, 3);

        // Data-memory stall beats muldiv_start; muldiv ignored on MEM_WAIT release
        dmem_req = 1; dmem_ready = 0; muldiv_start = 1;
        cycle("dm0", C_DST, 2'd0, 3);
        cycle("dm1", C_DST, 2'd1, 4);
        cycle("dm2", C_DST, 2'd1, 5);
        dmem_ready = 1; load_use_hazard = 1;
        cycle("dm_rel", C_LU, 2'd1, 6);
        idle();                                  cycle("dm_after", C_ALL, 2'd0, 7);

        // Saturation, then clear, then clear beating increment
        imem_ready = 0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
        end
        idle(); perf_clr = 1;                    cycle("sat", C_ALL, 2'd0, 15);
        perf_clr = 1; imem_ready = 0;            cycle("clr_inc", C_IMEM, 2'd0, 0);
        idle();                                  cycle("cleared", C_ALL, 2'd0, 0);

        // Plain mul/div: 4 cycles of EX occupancy, hazards ignored
        muldiv_start = 1;                        cycle("md0", C_MD, 2'd0, 0);
        branch_taken = 1; load_use_hazard = 1;   cycle("md1", C_MD, 2'd2, 1);
        cycle("md2", C_MD, 2'd2, 2);
        cycle("md3", C_DONE, 2'd2, 3);
        idle();                                  cycle("md_end", C_ALL, 2'd0, 4);

        // Memory stall at cnt==1 holds off muldiv_done
        muldiv_start = 1;                        cycle("ms0", C_MD, 2'd0, 4);
        muldiv_start = 0;                        cycle("ms1", C_MD, 2'd2, 5);
        cycle("ms2", C_MD, 2'd2, 6);
        dmem_req = 1; dmem_ready = 0;            cycle("ms3", C_DST, 2'd2, 7);
        cycle("ms4", C_DST, 2'd2, 8);
        dmem_ready = 1;                          cycle("ms5", C_DONE, 2'd2, 9);
        idle();                                  cycle("ms_end", C_ALL, 2'd0, 10);

        // Memory stall while cnt>1: countdown continues underneath
        muldiv_start = 1;                        cycle("mk0", C_MD, 2'd0, 10);
        muldiv_start = 0; dmem_req = 1; dmem_ready = 0;
        cycle("mk1", C_DST, 2'd2, 11);
        cycle("mk2", C_DST, 2'd2, 12);
        idle();                                  cycle("mk3", C_DONE, 2'd2, 13);
        cycle("mk_end", C_ALL, 2'd0, 14);

        // Asynchronous reset mid-MULDIV
        muldiv_start = 1;                        cycle("mr0", C_MD, 2'd0, 14);
        muldiv_start = 0;                        cycle("mr1", C_MD, 2'd2, 15);
        rst_n = 1'b0;
        #2;
        chk("mrst.ctl", 32'({pc_write, if_id_write, id_ex_write, ex_mem_write,
                             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                             muldiv_done}), 32'(C_RST));
        chk("mrst.state", 32'(ctrl_state), 32'd0);
        chk("mrst.stall", 32'(stall_cycles), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cycle("post0", C_ALL, 2'd0, 0);
        load_use_hazard = 1;                     cycle("post_lu", C_LU, 2'd0, 0);
        idle();                                  cycle("post1", C_ALL, 2'd0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
